// File: rtl/axi_lite_spi_slave_pkg.sv
// Shared register map, STATUS bit positions, response codes and FSM state types
// for the AXI-Lite SPI responder.
package axi_lite_spi_slave_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    localparam int unsigned STAT_RX_VALID    = 0;
    localparam int unsigned STAT_TX_FULL     = 1;
    localparam int unsigned STAT_RX_OVERRUN  = 2;
    localparam int unsigned STAT_TX_UNDERRUN = 3;
    localparam int unsigned STAT_BUSY        = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

endpackage

// File: rtl/spi_slave_shifter.sv
// Mode-0 SPI shift engine: input synchronizers, edge detection, bit counter,
// TX/RX shift registers and frame load/complete strobes.
module spi_slave_shifter
    import axi_lite_spi_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  spi_clk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_req,
    output logic                  frame_done,
    output logic [DATA_WIDTH-1:0] rx_word,
    output logic                  busy,
    output logic                  miso
);

    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    logic [2:0]            sclk_sync_q, sclk_sync_d;
    logic [2:0]            cs_sync_q, cs_sync_d;
    logic [1:0]            mosi_sync_q, mosi_sync_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], spi_clk};
        cs_sync_d   = {cs_sync_q[1:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[0], spi_mosi};
        cnt_d       = cnt_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load_req    = 1'b0;
        if (cs_rise) begin
            busy_d  = 1'b0;
            cnt_d   = '0;
            tx_sh_d = '0;
        end else if (cs_fall) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            load_req = 1'b1;
            tx_sh_d  = load_data;
        end else if (busy_q) begin
            if (sclk_rise && cnt_q != CW'(DATA_WIDTH)) begin
                rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], mosi_sync_q[1]};
                cnt_d   = cnt_q + CW'(1);
                done_d  = (cnt_q == CW'(DATA_WIDTH - 1));
            end else if (sclk_fall) begin
                // Trailing falling edge of a full frame reloads, enabling back-to-back frames
                if (cnt_q == CW'(DATA_WIDTH)) begin
                    cnt_d    = '0;
                    load_req = 1'b1;
                    tx_sh_d  = load_data;
                end else begin
                    tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // Synchronizers reset to "selected" so a cs_n held low across reset release
    // never produces a falling edge; the resulting spurious rise is harmless.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            cnt_q       <= '0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cnt_q       <= cnt_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign frame_done = done_q;
    assign rx_word    = rx_sh_q;
    assign busy       = busy_q;
    assign miso       = tx_sh_q[DATA_WIDTH-1];

endmodule

// File: rtl/axi_lite_spi_slave.sv
// AXI4-Lite register front end for the SPI responder: handshake FSMs,
// TX/RX holding registers and STATUS flags.
module axi_lite_spi_slave
    import axi_lite_spi_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        spi_clk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [31:0] axi_lite_awaddr,
    input  logic        axi_lite_awvalid,
    output logic        axi_lite_awready,
    input  logic [31:0] axi_lite_wdata,
    input  logic [3:0]  axi_lite_wstrb,
    input  logic        axi_lite_wvalid,
    output logic        axi_lite_wready,
    output logic [1:0]  axi_lite_bresp,
    output logic        axi_lite_bvalid,
    input  logic        axi_lite_bready,
    input  logic [31:0] axi_lite_araddr,
    input  logic        axi_lite_arvalid,
    output logic        axi_lite_arready,
    output logic [31:0] axi_lite_rdata,
    output logic [1:0]  axi_lite_rresp,
    output logic        axi_lite_rvalid,
    input  logic        axi_lite_rready
);

    wr_state_e             wr_state_q, wr_state_d;
    rd_state_e             rd_state_q, rd_state_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] tx_hold_q, tx_hold_d;
    logic [DATA_WIDTH-1:0] rx_hold_q, rx_hold_d;
    logic                  tx_full_q, tx_full_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_ovr_q, rx_ovr_d;
    logic                  tx_und_q, tx_und_d;

    logic                  aw_fire, ar_fire, rx_read;
    logic [1:0]            wr_addr, rd_addr;
    logic                  load_req, frame_done, busy;
    logic [DATA_WIDTH-1:0] rx_word, load_data;
    logic                  unused_ok;

    assign wr_addr   = axi_lite_awaddr[3:2];
    assign rd_addr   = axi_lite_araddr[3:2];
    assign aw_fire   = axi_lite_awvalid && axi_lite_wvalid && (wr_state_q == W_IDLE);
    assign ar_fire   = axi_lite_arvalid && (rd_state_q == R_IDLE);
    assign rx_read   = ar_fire && (rd_addr == REG_RXDATA);
    assign load_data = tx_full_q ? tx_hold_q : '0;
    assign unused_ok = ^{axi_lite_awaddr[31:4], axi_lite_awaddr[1:0],
                         axi_lite_araddr[31:4], axi_lite_araddr[1:0],
                         axi_lite_wstrb, axi_lite_wdata};

    spi_slave_shifter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shifter (
        .clk        (clk),
        .resetn     (resetn),
        .spi_clk    (spi_clk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .load_data  (load_data),
        .load_req   (load_req),
        .frame_done (frame_done),
        .rx_word    (rx_word),
        .busy       (busy),
        .miso       (spi_miso)
    );

    always_comb begin
        wr_state_d = wr_state_q;
        rd_state_d = rd_state_q;
        bresp_d    = bresp_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        tx_hold_d  = tx_hold_q;
        rx_hold_d  = rx_hold_q;
        tx_full_d  = tx_full_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        tx_und_d   = tx_und_q;

        unique case (wr_state_q)
            W_IDLE: if (aw_fire) begin
                wr_state_d = W_RESP;
                bresp_d    = (wr_addr == 2'd3) ? RESP_SLVERR : RESP_OKAY;
            end
            W_RESP: if (axi_lite_bready) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase

        unique case (rd_state_q)
            R_IDLE: if (ar_fire) begin
                rd_state_d = R_DATA;
                rresp_d    = RESP_OKAY;
                rdata_d    = '0;
                if (rd_addr == REG_RXDATA) begin
                    rdata_d[DATA_WIDTH-1:0] = rx_hold_q;
                end else if (rd_addr == REG_STATUS) begin
                    rdata_d[STAT_RX_VALID]    = rx_valid_q;
                    rdata_d[STAT_TX_FULL]     = tx_full_q;
                    rdata_d[STAT_RX_OVERRUN]  = rx_ovr_q;
                    rdata_d[STAT_TX_UNDERRUN] = tx_und_q;
                    rdata_d[STAT_BUSY]        = busy;
                end
            end
            R_DATA: if (axi_lite_rready) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase

        // Ordering matters: W1C clears first so hardware sets win; a read of RXDATA
        // frees the holding slot for a frame completing in the same cycle; a TXDATA
        // write lands after the frame load, which therefore sees the old tx_full.
        if (aw_fire && wr_addr == REG_STATUS) begin
            if (axi_lite_wdata[STAT_RX_OVERRUN])  rx_ovr_d = 1'b0;
            if (axi_lite_wdata[STAT_TX_UNDERRUN]) tx_und_d = 1'b0;
        end
        if (rx_read) rx_valid_d = 1'b0;
        if (load_req) begin
            if (tx_full_q) tx_full_d = 1'b0;
            else           tx_und_d  = 1'b1;
        end
        if (frame_done) begin
            if (rx_valid_q && !rx_read) begin
                rx_ovr_d = 1'b1;
            end else begin
                rx_hold_d  = rx_word;
                rx_valid_d = 1'b1;
            end
        end
        if (aw_fire && wr_addr == REG_TXDATA) begin
            tx_hold_d = axi_lite_wdata[DATA_WIDTH-1:0];
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            bresp_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            tx_hold_q  <= '0;
            rx_hold_q  <= '0;
            tx_full_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_und_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            tx_hold_q  <= tx_hold_d;
            rx_hold_q  <= rx_hold_d;
            tx_full_q  <= tx_full_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_und_q   <= tx_und_d;
        end
    end

    assign axi_lite_awready = aw_fire;
    assign axi_lite_wready  = aw_fire;
    assign axi_lite_bvalid  = (wr_state_q == W_RESP);
    assign axi_lite_bresp   = bresp_q;
    assign axi_lite_arready = ar_fire;
    assign axi_lite_rvalid  = (rd_state_q == R_DATA);
    assign axi_lite_rdata   = rdata_q;
    assign axi_lite_rresp   = rresp_q;

endmodule
